// File: rtl/fwd_pkg.sv
// Shared types for the operand bypass and hazard unit.
// Bypass sources are bundled as one struct per pipeline stage.
package fwd_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    logic                wreg;
    reg_addr_t           rd;
    logic [XLEN_DEF-1:0] data;
    logic                ready;
  } byp_src_t;

endpackage

// File: rtl/fwd_port_mux.sv
// One read port's bypass select: youngest matching stage wins,
// and a not-ready youngest match blocks any older match.
module fwd_port_mux
  import fwd_pkg::*;
#(
  parameter int NSTAGE = 3
) (
  input  reg_addr_t           rsAddr,
  input  logic [XLEN_DEF-1:0] rsRf,
  input  byp_src_t            src [NSTAGE],
  output logic [XLEN_DEF-1:0] fwdData,
  output logic                notReady
);

  logic hit;

  always_comb begin
    fwdData  = rsRf;
    notReady = 1'b0;
    hit      = 1'b0;
    for (int s = 0; s < NSTAGE; s++) begin
      if (!hit && src[s].wreg &&
          src[s].rd == rsAddr &&
          rsAddr != '0) begin
        hit = 1'b1;
        if (src[s].ready) fwdData = src[s].data;
        else notReady = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand bypass, multi-cycle latency scoreboard and stall counter
// for the decode stage of the pipelined core.
module hazard_forward_unit
  import fwd_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREAD  = 2,
  parameter int NSTAGE = 3,
  parameter int NREG   = NREG_DEF,
  parameter int MAXLAT = 8,
  localparam int LW    = $clog2(MAXLAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  reg_addr_t         rs_addr   [NREAD],
  input  logic [XLEN-1:0]   rs_rf     [NREAD],
  output logic [XLEN-1:0]   rs_fwd    [NREAD],
  input  logic [NSTAGE-1:0] byp_wreg,
  input  reg_addr_t         byp_rd    [NSTAGE],
  input  logic [XLEN-1:0]   byp_data  [NSTAGE],
  input  logic [NSTAGE-1:0] byp_ready,
  input  logic              issue_valid,
  input  logic              issue_wreg,
  input  reg_addr_t         issue_rd,
  input  logic [LW-1:0]     issue_lat,
  input  logic              flush,
  output logic              stall,
  output logic [31:0]       stall_cnt
);

  if (XLEN != XLEN_DEF) begin : gXlenChk
    $error("XLEN must equal fwd_pkg::XLEN_DEF");
  end

  byp_src_t      src [NSTAGE];
  logic          notReady [NREAD];
  logic [LW-1:0] cnt [NREG];
  logic [LW-1:0] latClamp;
  logic          issueAcc;
  logic [31:0]   stallCntQ;

  always_comb begin
    for (int s = 0; s < NSTAGE; s++) begin
      src[s].wreg  = byp_wreg[s];
      src[s].rd    = byp_rd[s];
      src[s].data  = byp_data[s];
      src[s].ready = byp_ready[s];
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : gPort
    fwd_port_mux #(
      .NSTAGE(NSTAGE)
    ) uMux (
      .rsAddr  (rs_addr[p]),
      .rsRf    (rs_rf[p]),
      .src     (src),
      .fwdData (rs_fwd[p]),
      .notReady(notReady[p])
    );
  end

  always_comb begin
    stall = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      if (rs_addr[p] != '0 &&
          (cnt[rs_addr[p]] != '0 || notReady[p]))
        stall = 1'b1;
    end
  end

  // A flush drops any issue presented in the same cycle.
  assign issueAcc = issue_valid && !stall && issue_wreg &&
                    issue_rd != '0 && !flush;

  assign latClamp = (issue_lat > LW'(MAXLAT)) ?
                    LW'(MAXLAT) : issue_lat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0 || flush)
          cnt[r] <= '0;
        else if (issueAcc && issue_rd == 5'(r))
          cnt[r] <= latClamp;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stallCntQ <= '0;
    else if (stall && stallCntQ != '1)
      stallCntQ <= stallCntQ + 32'd1;
  end

  assign stall_cnt = stallCntQ;

  latClampChk: assert property (
    @(posedge clk) disable iff (rst)
    issueAcc |-> issue_lat <= LW'(MAXLAT)
  ) else $warning("issue_lat above MAXLAT, clamped");

endmodule
